// File: rtl/adder_pkg.sv
// Shared types and constants for the ripple-carry and bit-serial adder family.
package adder_pkg;

    // Single-bit operand/result type used by ripple and serial adders.
    typedef logic bit_t;

    // Default carry value restored by reset in bit-serial adders.
    localparam bit_t CARRY_RESET = 1'b0;

endpackage : adder_pkg

// File: rtl/fa_cell.sv
// Gate-level full-adder cell built only from XOR/AND/OR.
// Ports:
//   a_i, b_i   - addend bits
//   c_i        - carry-in bit
//   sum_c_o    - combinational sum
//   carry_c_o  - combinational carry-out
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_c_o,
    output logic carry_c_o
);

    logic half_x;

    // The half-sum is shared by the sum and the propagate term of the carry.
    assign half_x    = a_i ^ b_i;
    assign sum_c_o   = half_x ^ c_i;
    assign carry_c_o = (a_i & b_i) | (c_i & half_x);

endmodule : fa_cell

// File: rtl/full_adder_bitwise.sv
// Single-bit full adder with a combinational result and a clocked side path
// offering a registered result and bit-serial accumulation with stored carry.
// Ports:
//   a, b, cin  - operand bits and carry-in
//   sum, cout  - combinational result, independent of clk/rst/en/serial
//   clk, rst   - clock and asynchronous active-high reset
//   en         - register update enable
//   serial     - 1: carry source is carry_q, 0: carry source is cin
//   sum_q      - registered sum
//   cout_q     - registered carry-out
//   carry_q    - stored carry between serial bits
module full_adder_bitwise
    import adder_pkg::*;
#(
    parameter int unsigned SERIAL_EN_DEFAULT = 32'(CARRY_RESET)
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout,
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic serial,
    output logic sum_q,
    output logic cout_q,
    output logic carry_q
);

    localparam bit_t CARRY_RST_VAL = SERIAL_EN_DEFAULT[0];

    logic csel;
    logic s_n;
    logic c_n;
    logic sum_d;
    logic cout_d;
    logic carry_d;

    // Combinational result path; touches none of the clocked controls.
    fa_cell u_fa_comb (
        .a_i       (a),
        .b_i       (b),
        .c_i       (cin),
        .sum_c_o   (sum),
        .carry_c_o (cout)
    );

    // Registered path adds against either cin or the stored serial carry.
    assign csel = serial ? carry_q : cin;

    fa_cell u_fa_reg (
        .a_i       (a),
        .b_i       (b),
        .c_i       (csel),
        .sum_c_o   (s_n),
        .carry_c_o (c_n)
    );

    // Next-state: hold unless enabled; a parallel-mode cycle clears the carry
    // so the following serial word starts fresh.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        if (en) begin
            sum_d   = s_n;
            cout_d  = c_n;
            carry_d = serial ? c_n : 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
            carry_q <= CARRY_RST_VAL;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
        end
    end

endmodule : full_adder_bitwise

// File: tb/tb_full_adder_bitwise.sv
// Directed self-checking bench for full_adder_bitwise.
module tb_full_adder_bitwise;

    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
    logic clk;
    logic rst;
    logic en;
    logic serial;
    logic sum_q;
    logic cout_q;
    logic carry_q;

    logic clk_run;
    int   checks;
    int   failures;

    full_adder_bitwise #(.SERIAL_EN_DEFAULT(0)) dut (
        .a       (a),
        .b       (b),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout),
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .serial  (serial),
        .sum_q   (sum_q),
        .cout_q  (cout_q),
        .carry_q (carry_q)
    );

    // Clock is held low until clk_run is set, so the combinational sweep sees an idle clock.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] comb_tbl [8];
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] exp_s;

        // {cout,sum} for {a,b,cin} = 0..7
        comb_tbl[0] = 2'b00; comb_tbl[1] = 2'b01; comb_tbl[2] = 2'b01; comb_tbl[3] = 2'b10;
        comb_tbl[4] = 2'b01; comb_tbl[5] = 2'b10; comb_tbl[6] = 2'b10; comb_tbl[7] = 2'b11;

        checks   = 0;
        failures = 0;
        clk_run  = 1'b0;
        rst      = 1'b0;
        en       = 1'b0;
        serial   = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0;

        // Combinational sweep with clock and reset idle.
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = 3'(i);
            #10;
            check($sformatf("comb_%0d", i), {cout, sum}, comb_tbl[i]);
        end

        // Asynchronous reset with no clock running.
        rst = 1'b1;
        #3;
        check("rst_sum_q", {1'b0, sum_q}, 2'b00);
        check("rst_cout_q", {1'b0, cout_q}, 2'b00);
        check("rst_carry_q", {1'b0, carry_q}, 2'b00);

        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = 1'b1; serial = 1'b0;
        a = 1'b1; b = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        check("par_100_sum_q", {1'b0, sum_q}, 2'b01);

        // Mid-cycle reset clears registers immediately and holds them.
        a = 1'b1; b = 1'b1; cin = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("midrst_regs", {sum_q, cout_q}, 2'b00);
        check("midrst_carry", {1'b0, carry_q}, 2'b00);
        @(posedge clk); #1;
        check("rst_held_regs", {sum_q, cout_q}, 2'b00);
        check("rst_held_carry", {1'b0, carry_q}, 2'b00);

        // Parallel registered add 1+1+0.
        @(negedge clk);
        rst = 1'b0;
        a = 1'b1; b = 1'b1; cin = 1'b0;
        @(posedge clk); #1;
        check("par_110_couts", {cout_q, sum_q}, 2'b10);
        check("par_110_carry", {1'b0, carry_q}, 2'b00);

        // Enable low: registers hold, combinational outputs keep tracking.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en = 1'b0;
            {a, b, cin} = 3'(7 - i);
            #1;
            check($sformatf("hold_comb_%0d", 7 - i), {cout, sum}, comb_tbl[7 - i]);
            @(posedge clk); #1;
            check($sformatf("hold_regs_%0d", i), {cout_q, sum_q}, 2'b10);
            check($sformatf("hold_carry_%0d", i), {1'b0, carry_q}, 2'b00);
        end

        // Serial add 0b1011 + 0b0111 LSB first = 0b10010.
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        serial = 1'b1; en = 1'b1; cin = 1'b0;
        sa = 4'b1011; sb = 4'b0111; exp_s = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            a = sa[k]; b = sb[k];
            @(posedge clk); #1;
            check($sformatf("ser_sum_%0d", k), {1'b0, sum_q}, {1'b0, exp_s[k]});
        end
        check("ser_final_carry", {1'b0, carry_q}, 2'b01);
        check("ser_final_cout", {1'b0, cout_q}, 2'b01);

        // One parallel-mode enabled cycle clears the stored carry.
        @(negedge clk);
        serial = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        check("par_clear_carry", {1'b0, carry_q}, 2'b00);

        // Serial word interrupted by reset after two bits.
        serial = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a = sa[k]; b = sb[k];
            @(posedge clk); #1;
        end
        check("mid_word_carry", {1'b0, carry_q}, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("mid_word_rst_carry", {1'b0, carry_q}, 2'b00);

        // Restart with 0b0001 + 0b0001 = 0b0010.
        sa = 4'b0001; sb = 4'b0001; exp_s = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst = 1'b0;
            a = sa[k]; b = sb[k];
            @(posedge clk); #1;
            check($sformatf("restart_sum_%0d", k), {1'b0, sum_q}, {1'b0, exp_s[k]});
        end
        check("restart_final_carry", {1'b0, carry_q}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_full_adder_bitwise
